act_unit_pipe: RTL and testbench
================================

// Module: act_unit_pipe
// PURPOSE
//   Multi-lane activation unit with runtime mode select; next generation of the fixed leaky-ReLU stage.
//   Applies identity / ReLU / leaky-ReLU / clipped-ReLU (ReLU6) to NUM_CH packed 2's-complement lanes.
//   Sits between the accumulator output and the requantiser.
//   2-stage valid/ready pipeline with backpressure, plus a saturation event counter.
// PARAMETERS
//   DATA_WIDTH  16  lane width, signed 2's complement
//   NUM_CH      4   lanes per beat
//   NEG_SHIFT   5   leaky slope = 2^-NEG_SHIFT (arithmetic shift right)
//   FRAC_BITS   8   fractional bits of lane format; CLIP_MAX = 6 << FRAC_BITS (1536 at defaults)
//   CNT_WIDTH   16  width of saturation counter
// PORTS
//   clk         in   1                   clock, rising edge
//   rst_n       in   1                   asynchronous reset, active low
//   i_en        in   1                   global enable; 0 freezes both stages
//   i_valid     in   1                   input beat valid
//   o_ready     out  1                   unit can accept a beat this cycle
//   i_mode      in   2                   0 identity, 1 ReLU, 2 leaky, 3 ReLU6; sampled with the beat
//   i_data_bus  in   NUM_CH*DATA_WIDTH   lanes; lane k = bits [k*DW +: DW]
//   o_valid     out  1                   output beat valid
//   i_ready     in   1                   downstream accepts output
//   o_data_bus  out  NUM_CH*DATA_WIDTH   activated lanes, same format as input
//   i_clr       in   1                   synchronous clear of o_sat_cnt
//   o_sat_cnt   out  CNT_WIDTH           number of lanes clipped high in mode 3
// BEHAVIOUR
//   Reset: o_valid=0, o_data_bus=0, o_sat_cnt=0, internal stage-1 valid=0; o_ready follows the equations below.
//   Stage enables:
//     s2_en = i_en & (!o_valid | i_ready)
//     s1_en = i_en & (!s1_valid | s2_en)
//     o_ready = s1_en (combinational from i_ready; allowed).
//   Accept: i_valid & o_ready. The beat is captured into stage 1 with its mode.
//   Stage 1 computes the function per lane. Stage 2 is the output register.
//   Latency: 2 cycles, accept edge to o_valid, with no stall. Throughput: 1 beat/cycle.
//   On stage-1 advance with no new accept, s1_valid <= 0.
//   On stage-2 advance with s1_valid=0, o_valid <= 0.
//   Stall: o_valid=1 & i_ready=0 -> o_data_bus held stable; stage 1 fills, then o_ready=0.
//   i_en=0: no state changes, o_ready=0, outputs hold. The counter also holds but i_clr still clears it.
//   Per-lane function on x:
//     mode 0: x
//     mode 1: x<0 ? 0 : x
//     mode 2: x<0 ? x>>>NEG_SHIFT : x. Floor semantics: -1 -> -1, -32 -> -1, -33 -> -2.
//     mode 3: x<0 ? 0 : (x>CLIP_MAX ? CLIP_MAX : x). x==CLIP_MAX is not clipped.
//   Most negative input (0x8000) is handled without overflow in every mode.
//   Saturation counter:
//     On each stage-1 capture in mode 3, adds the number of lanes with x>CLIP_MAX.
//     Saturates at all-ones; no wrap.
//     i_clr=1 -> 0 next edge. Clear wins; that cycle's increment is discarded.
//   Mode changes between beats take effect per beat; no pipeline flush needed.
//   Reset mid-operation: in-flight beats are dropped, with no partial output.
// TESTING
//   T1 mode2, lanes {100,-1,-32,-33}, i_ready=1 -> 2 cycles later o_data_bus={100,-1,-1,-2}, o_valid for 1 cycle.
//   T2 mode3, lanes {1536,1537,-5,32767} -> {1536,1536,0,1536}; o_sat_cnt goes 0->2.
//   T3 back-to-back 8 beats with i_ready=0 from beat 2:
//      o_ready drops after 2 beats held; no beat lost or duplicated; order kept when i_ready returns.
//   T4 alternating modes 0/1/2/3 on lane value 0x8000 -> {0x8000, 0, 0xFC00, 0}, mode per beat respected.
//   T5 i_clr asserted in the same cycle as a mode-3 beat with 4 clipped lanes -> o_sat_cnt=0 next cycle.
//      Counter preset near max (via many beats, CNT_WIDTH=4) sticks at 15.
//   T6 rst_n low while both stages full and o_valid=1 -> async: o_valid=0, o_data_bus=0, o_sat_cnt=0 immediately.
//      First beat after release appears 2 cycles after accept.

Source files
------------

// File: rtl/act_unit_pipe.sv
// Multi-lane activation unit: identity / ReLU / leaky-ReLU / ReLU6 on NUM_CH packed signed lanes,
// behind a 2-stage valid/ready pipeline with a saturating clip-event counter.
module act_unit_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 4,
  parameter int NEG_SHIFT  = 5,
  parameter int FRAC_BITS  = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_en,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [1:0]                   i_mode,
  input  logic [NUM_CH*DATA_WIDTH-1:0] i_data_bus,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [NUM_CH*DATA_WIDTH-1:0] o_data_bus,
  input  logic                         i_clr,
  output logic [CNT_WIDTH-1:0]         o_sat_cnt
);

  localparam int BW = NUM_CH * DATA_WIDTH;
  localparam int IW = $clog2(NUM_CH + 1);
  localparam int SW = CNT_WIDTH + IW;
  localparam logic signed [DATA_WIDTH-1:0] CLIP_MAX = DATA_WIDTH'(6 << FRAC_BITS);

  // Handshake: a beat moves on a rising edge when valid & ready are both high on that side.
  // A stage advances when its successor is empty or advancing; i_en=0 blocks every advance.
  logic          r_s1_valid;
  logic [BW-1:0] r_s1_data;
  logic          r_o_valid;
  logic [BW-1:0] r_o_data;
  logic [CNT_WIDTH-1:0] r_sat_cnt;

  logic          w_s2_en;
  logic          w_s1_en;
  logic          w_accept;
  logic [BW-1:0] w_act;
  logic [IW-1:0] w_clip_n;
  logic [SW-1:0] w_cnt_sum;
  logic [CNT_WIDTH-1:0] w_cnt_next;

  function automatic logic [DATA_WIDTH-1:0] act_fn(
    input logic [1:0]                   mode,
    input logic signed [DATA_WIDTH-1:0] x
  );
    logic neg;
    neg = x[DATA_WIDTH-1];
    case (mode)
      2'd0:    act_fn = x;
      2'd1:    act_fn = neg ? '0 : x;
      2'd2:    act_fn = neg ? (x >>> NEG_SHIFT) : x;
      default: act_fn = neg ? '0 : ((x > CLIP_MAX) ? CLIP_MAX : x);
    endcase
  endfunction

  assign w_s2_en  = i_en & (~r_o_valid | i_ready);
  assign w_s1_en  = i_en & (~r_s1_valid | w_s2_en);
  assign o_ready  = w_s1_en;
  assign w_accept = i_valid & w_s1_en;

  always_comb begin
    w_act    = '0;
    w_clip_n = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_act[k*DATA_WIDTH +: DATA_WIDTH] = act_fn(i_mode, $signed(i_data_bus[k*DATA_WIDTH +: DATA_WIDTH]));
      if ((i_mode == 2'd3) && ($signed(i_data_bus[k*DATA_WIDTH +: DATA_WIDTH]) > CLIP_MAX))
        w_clip_n = w_clip_n + IW'(1);
    end
  end

  // Widened sum so the all-ones clamp sees any overflow instead of wrapping.
  assign w_cnt_sum  = SW'(r_sat_cnt) + SW'(w_clip_n);
  assign w_cnt_next = (w_cnt_sum > SW'({CNT_WIDTH{1'b1}})) ? {CNT_WIDTH{1'b1}} : w_cnt_sum[CNT_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_o_valid  <= 1'b0;
      r_o_data   <= '0;
      r_sat_cnt  <= '0;
    end else begin
      if (w_s1_en) begin
        r_s1_valid <= w_accept;
        if (w_accept) r_s1_data <= w_act;
      end
      if (w_s2_en) begin
        r_o_valid <= r_s1_valid;
        if (r_s1_valid) r_o_data <= r_s1_data;
      end
      // Clear is independent of i_en and overrides a same-cycle increment.
      if (i_clr)
        r_sat_cnt <= '0;
      else if (w_accept && (i_mode == 2'd3))
        r_sat_cnt <= w_cnt_next;
    end
  end

  assign o_valid    = r_o_valid;
  assign o_data_bus = r_o_data;
  assign o_sat_cnt  = r_sat_cnt;

endmodule

// File: tb/tb_act_unit_pipe.sv
// Scoreboard bench for act_unit_pipe: directed beats plus random traffic with backpressure/enable gaps.
module tb_act_unit_pipe;
  localparam int DW  = 16;
  localparam int NC  = 4;
  localparam int BW  = DW * NC;
  localparam int CW  = 4;
  localparam int CLIP = 1536;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_en = 1'b1;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [1:0]    i_mode = 2'd0;
  logic [BW-1:0] i_data_bus = '0;
  logic          o_valid;
  logic          i_ready = 1'b1;
  logic [BW-1:0] o_data_bus;
  logic          i_clr = 1'b0;
  logic [CW-1:0] o_sat_cnt;

  logic [BW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_fail = 0;
  int            n_acc = 0;
  int            exp_cnt = 0;
  logic          held_pending = 1'b0;
  logic [BW-1:0] held_data = '0;
  logic          rnd_done;

  act_unit_pipe #(.DATA_WIDTH(DW), .NUM_CH(NC), .NEG_SHIFT(5), .FRAC_BITS(8), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .i_en(i_en), .i_valid(i_valid), .o_ready(o_ready),
    .i_mode(i_mode), .i_data_bus(i_data_bus), .o_valid(o_valid), .i_ready(i_ready),
    .o_data_bus(o_data_bus), .i_clr(i_clr), .o_sat_cnt(o_sat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] pack4(input int l0, input int l1, input int l2, input int l3);
    logic [DW-1:0] a, b, c, d;
    a = DW'(l0); b = DW'(l1); c = DW'(l2); d = DW'(l3);
    return {d, c, b, a};
  endfunction

  // Reference activation in integer arithmetic (floor division for the leaky slope 1/32).
  function automatic int ref_lane(input logic [1:0] m, input int x);
    case (m)
      2'd0: return x;
      2'd1: return (x < 0) ? 0 : x;
      2'd2: return (x < 0) ? (x - 31) / 32 : x;
      default: return (x < 0) ? 0 : ((x > CLIP) ? CLIP : x);
    endcase
  endfunction

  function automatic logic [BW-1:0] ref_bus(input logic [1:0] m, input logic [BW-1:0] d);
    logic [BW-1:0] r;
    r = '0;
    for (int k = 0; k < NC; k++)
      r[k*DW +: DW] = DW'(ref_lane(m, int'($signed(d[k*DW +: DW]))));
    return r;
  endfunction

  function automatic int n_clip(input logic [BW-1:0] d);
    int n;
    n = 0;
    for (int k = 0; k < NC; k++)
      if (int'($signed(d[k*DW +: DW])) > CLIP) n++;
    return n;
  endfunction

  // Drive one beat (inputs change at posedge+1), wait for acceptance, push the expectation.
  task automatic send(input logic [1:0] m, input logic [BW-1:0] d, input logic [BW-1:0] exp, input logic clr);
    int  tries;
    logic ok;
    tries = 0;
    i_valid = 1'b1; i_mode = m; i_data_bus = d; i_clr = clr;
    do begin
      @(negedge clk);
      ok = o_ready;
      if (!ok) begin
        @(posedge clk); #1;
        tries++;
      end
    end while (!ok && tries < 300);
    if (!ok) begin
      chk("accept_timeout", 0, 1);
      i_valid = 1'b0; i_clr = 1'b0;
    end else begin
      exp_q.push_back(exp);
      n_acc++;
      if (clr) exp_cnt = 0;
      else if (m == 2'd3) exp_cnt = (exp_cnt + n_clip(d) > 15) ? 15 : exp_cnt + n_clip(d);
      @(posedge clk); #1;
      i_valid = 1'b0; i_clr = 1'b0;
      chk("sat_cnt", BW'(o_sat_cnt), BW'(exp_cnt));
    end
  endtask

  task automatic send_m(input logic [1:0] m, input logic [BW-1:0] d);
    send(m, d, ref_bus(m, d), 1'b0);
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    chk("drain", BW'(exp_q.size()), '0);
  endtask

  function automatic int pick_lane();
    int tbl[10] = '{0, 1, -1, -32, -33, 1535, 1536, 1537, 32767, -32768};
    if ($urandom_range(0, 1) == 0) return tbl[$urandom_range(0, 9)];
    return int'($signed(16'($urandom_range(0, 65535))));
  endfunction

  // Output monitor: transfer happens at the next posedge when o_valid & i_ready & i_en.
  always @(negedge clk) begin
    if (!rst_n) begin
      held_pending <= 1'b0;
    end else begin
      if (held_pending) chk("stall_hold", o_data_bus, held_data);
      if (o_valid && i_ready && i_en) begin
        if (exp_q.size() == 0) chk("unexpected_beat", o_data_bus, 'x);
        else chk("data", o_data_bus, exp_q.pop_front());
      end
      held_pending <= o_valid && !(i_ready && i_en);
      held_data    <= o_data_bus;
    end
  end

  initial begin
    #200000;
    chk("global_timeout", 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    int base;
    logic [BW-1:0] d;
    logic [1:0] m;
    // Reset state
    #12;
    chk("rst_valid", BW'(o_valid), '0);
    chk("rst_data", o_data_bus, '0);
    chk("rst_cnt", BW'(o_sat_cnt), '0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    // T1 leaky floor and one-cycle output pulse
    send(2'd2, pack4(100, -1, -32, -33), pack4(100, -1, -1, -2), 1'b0);
    chk("t1_lat1", BW'(o_valid), '0);
    @(posedge clk); #1;
    chk("t1_lat2", BW'(o_valid), 1);
    chk("t1_data", o_data_bus, pack4(100, -1, -1, -2));
    @(posedge clk); #1;
    chk("t1_pulse", BW'(o_valid), '0);

    // T2 ReLU6 clip boundary and counter 0 -> 2
    send(2'd3, pack4(1536, 1537, -5, 32767), pack4(1536, 1536, 0, 1536), 1'b0);
    drain();

    // T4 most-negative input in each mode
    d = pack4(-32768, -32768, -32768, -32768);
    send(2'd0, d, pack4(-32768, -32768, -32768, -32768), 1'b0);
    send(2'd1, d, '0, 1'b0);
    send(2'd2, d, pack4(-1024, -1024, -1024, -1024), 1'b0);
    send(2'd3, d, '0, 1'b0);
    drain();

    // T3 backpressure: two beats held, then o_ready low, order kept on release
    i_ready = 1'b0;
    base = n_acc;
    fork
      begin
        for (int b = 0; b < 8; b++) begin
          m = 2'($urandom_range(0, 3));
          send_m(m, pack4(pick_lane(), pick_lane(), pick_lane(), b * 100 - 300));
        end
      end
      begin
        for (int c = 0; c < 40 && n_acc - base < 2; c++) begin
          @(posedge clk); #1;
        end
        repeat (4) begin @(posedge clk); #1; end
        chk("t3_held", BW'(n_acc - base), BW'(2));
        chk("t3_oready", BW'(o_ready), '0);
        chk("t3_ovalid", BW'(o_valid), 1);
        i_en = 1'b0;
        #1 chk("en0_oready", BW'(o_ready), '0);
        @(posedge clk); #1;
        i_en = 1'b1;
        i_ready = 1'b1;
      end
    join
    drain();

    // T5 clear wins over a 4-clip beat; saturation sticks at 15
    send(2'd3, pack4(2000, 2000, 2000, 2000), pack4(CLIP, CLIP, CLIP, CLIP), 1'b1);
    for (int b = 0; b < 5; b++)
      send(2'd3, pack4(1537, 4000, 32767, 1600), pack4(CLIP, CLIP, CLIP, CLIP), 1'b0);
    chk("t5_sat", BW'(o_sat_cnt), BW'(15));
    drain();
    i_en = 1'b0; i_clr = 1'b1;
    @(posedge clk); #1;
    i_en = 1'b1; i_clr = 1'b0; exp_cnt = 0;
    chk("clr_while_disabled", BW'(o_sat_cnt), '0);

    // Random traffic with i_ready / i_en gaps
    rnd_done = 1'b0;
    fork
      begin
        for (int b = 0; b < 40; b++) begin
          m = 2'($urandom_range(0, 3));
          send_m(m, pack4(pick_lane(), pick_lane(), pick_lane(), pick_lane()));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          i_ready = ($urandom_range(0, 3) != 0);
          i_en    = ($urandom_range(0, 7) != 0);
        end
        i_ready = 1'b1; i_en = 1'b1;
      end
    join
    drain();

    // T6 async reset with both stages full
    i_ready = 1'b0;
    send(2'd3, pack4(1600, 1700, 0, 0), pack4(CLIP, CLIP, 0, 0), 1'b0);
    send_m(2'd1, pack4(5, -5, 7, -7));
    #3 rst_n = 1'b0;
    #1;
    chk("t6_valid", BW'(o_valid), '0);
    chk("t6_data", o_data_bus, '0);
    chk("t6_cnt", BW'(o_sat_cnt), '0);
    exp_q.delete();
    exp_cnt = 0;
    i_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_m(2'd2, pack4(-64, 64, -65, 3));
    chk("t6_lat1", BW'(o_valid), '0);
    @(posedge clk); #1;
    chk("t6_lat2", BW'(o_valid), 1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
